// File: rtl/cardinal_pkg.sv
// cardinal_pkg: NIC register map, sequencer state encoding and status-bit helper.
package cardinal_pkg;
  localparam logic [0:1] NIC_ADDR_IBUF  = 2'b00;
  localparam logic [0:1] NIC_ADDR_ISTAT = 2'b01;
  localparam logic [0:1] NIC_ADDR_OBUF  = 2'b10;
  localparam logic [0:1] NIC_ADDR_OSTAT = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE, S_RX_STAT, S_RX_CHK, S_RX_READ, S_RX_CAPT, S_TX_STAT, S_TX_CHK, S_TX_WRITE
  } state_t;
  function automatic int stat_bit(input int w);
    return w - 1;
  endfunction
endpackage

// File: rtl/cardinal_sync_fifo.sv
// cardinal_sync_fifo: single-clock FIFO with extra pointer bit for full/empty; head reads 0 when empty.
module cardinal_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [0:W-1] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [0:W-1] o_head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  r_wr, r_rd;
  logic [0:W-1] r_mem [DEPTH];
  logic         w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/cardinal_nic_ctrl.sv
// cardinal_nic_ctrl: polls a cardinal NIC register file, draining RX words into a FIFO
// and writing TX words when the output buffer is empty, alternating fairly between sides.
module cardinal_nic_ctrl
  import cardinal_pkg::*;
#(
  parameter int W        = 64,
  parameter int RX_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic [0:1]   nic_addr,
  output logic         nic_en,
  output logic         nic_wr_en,
  output logic [0:W-1] nic_d_in,
  input  logic [0:W-1] nic_d_out,
  input  logic         tx_valid,
  input  logic [0:W-1] tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [0:W-1] rx_data,
  input  logic         rx_ready
);
  localparam int SB = stat_bit(W);
  state_t r_state, w_next;
  logic   r_last_tx, w_full, w_empty, w_go_rx, w_go_tx, w_stat;
  cardinal_sync_fifo #(.W(W), .DEPTH(RX_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (r_state == S_RX_CAPT),
    .i_data (nic_d_out),
    .i_pop  (rx_ready),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (rx_data)
  );
  assign rx_valid = !w_empty;
  assign w_stat   = nic_d_out[SB];
  // Ties go to the side not served last; reset leaves TX as last so RX goes first.
  assign w_go_rx  = !w_full && (!tx_valid || r_last_tx);
  assign w_go_tx  = tx_valid && !w_go_rx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_last_tx <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (w_go_rx || w_go_tx)) r_last_tx <= w_go_tx;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = w_go_rx ? S_RX_STAT : w_go_tx ? S_TX_STAT : S_IDLE;
      S_RX_STAT:  w_next = S_RX_CHK;
      S_RX_CHK:   w_next = w_stat ? S_RX_READ : S_IDLE;
      S_RX_READ:  w_next = S_RX_CAPT;
      S_TX_STAT:  w_next = S_TX_CHK;
      S_TX_CHK:   w_next = w_stat ? S_IDLE : S_TX_WRITE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_comb begin
    nic_en    = r_state inside {S_RX_STAT, S_RX_READ, S_TX_STAT, S_TX_WRITE};
    nic_wr_en = r_state == S_TX_WRITE;
    tx_ready  = r_state == S_TX_WRITE;
    nic_d_in  = (r_state == S_TX_WRITE) ? tx_data : '0;
    nic_addr  = (r_state == S_RX_STAT) ? NIC_ADDR_ISTAT :
                (r_state == S_TX_STAT) ? NIC_ADDR_OSTAT :
                (r_state == S_TX_WRITE) ? NIC_ADDR_OBUF : NIC_ADDR_IBUF;
  end
endmodule

// File: tb/tb_cardinal_nic_ctrl.sv
// tb_cardinal_nic_ctrl: cycle-table check of the sequencer plus NIC-model sequences for
// FIFO-full backpressure, busy output buffer, fair alternation and reset during TX_CHK.
module tb_cardinal_nic_ctrl;
  localparam int W = 64;
  localparam logic [63:0] D = 64'hDEADBEEF_00000001;
  localparam logic [63:0] T = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0, reset = 1'b0;
  logic [0:1] nic_addr;
  logic nic_en, nic_wr_en, tx_ready, rx_valid;
  logic [0:W-1] nic_d_in, nic_d_out, rx_data;
  logic tx_valid = 1'b0, rx_ready = 1'b0;
  logic [0:W-1] tx_data = T;

  logic model_on = 1'b0, out_busy = 1'b0;
  logic [0:W-1] t_dout = '0, m_dout;
  logic [63:0] in_q[$];
  byte turn_log[$];
  int r01 = 0, r00 = 0, r11 = 0, wr_cnt = 0, txr_cnt = 0;
  logic [63:0] last_wr = '0;
  int n_run = 0, n_fail = 0;

  cardinal_nic_ctrl #(.W(W), .RX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .nic_addr(nic_addr), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .nic_d_in(nic_d_in), .nic_d_out(nic_d_out), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;
  assign nic_d_out = model_on ? m_dout : t_dout;

  // NIC register file: registered reads, input status = words pending, output status = out_busy
  always @(posedge clk) begin
    if (!reset) m_dout <= '0;
    else if (model_on) begin
      if (tx_ready) txr_cnt++;
      if (nic_en && !nic_wr_en) begin
        case (nic_addr)
          2'b00: begin
            r00++;
            m_dout <= (in_q.size() != 0) ? in_q[0] : '0;
            if (in_q.size() != 0) void'(in_q.pop_front());
          end
          2'b01: begin
            r01++;
            turn_log.push_back("R");
            m_dout <= 64'(in_q.size() != 0);
          end
          2'b11: begin
            r11++;
            turn_log.push_back("T");
            m_dout <= 64'(out_busy);
          end
          default: m_dout <= '0;
        endcase
      end else if (nic_en && nic_wr_en && nic_addr == 2'b10) begin
        wr_cnt++;
        last_wr = nic_d_in;
      end
    end
  end

  typedef struct {
    logic tv, rr;
    logic [63:0] dout;
    logic [133:0] exp;
  } vec_t;
  vec_t tbl[26];

  function automatic vec_t v(input logic tv, rr, input logic [63:0] dout, input logic en, wr,
                             input logic [1:0] addr, input logic [63:0] din, input logic txr, rxv,
                             input logic [63:0] rxd);
    vec_t r;
    r.tv = tv; r.rr = rr; r.dout = dout;
    r.exp = {en, wr, addr, din, txr, rxv, rxd};
    return r;
  endfunction

  function automatic logic [133:0] outs();
    return {nic_en, nic_wr_en, nic_addr, nic_d_in, tx_ready, rx_valid, rx_data};
  endfunction

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_q.delete();
    turn_log.delete();
    r01 = 0; r00 = 0; r11 = 0; wr_cnt = 0; txr_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = v(0, 0, D, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = v(1, 0, 0, 0, 0, 0, 0, 0, 1, D);
    tbl[9]  = v(1, 0, 0, 1, 0, 3, 0, 0, 1, D);
    tbl[10] = v(1, 0, 0, 0, 0, 0, 0, 0, 1, D);
    tbl[11] = v(1, 0, 0, 1, 1, 2, T, 1, 1, D);
    tbl[12] = v(0, 1, 0, 0, 0, 0, 0, 0, 1, D);
    tbl[13] = v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = v(1, 0, 0, 1, 0, 3, 0, 0, 0, 0);
    tbl[17] = v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = v(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[20] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[21] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[22] = v(1, 0, 0, 1, 0, 3, 0, 0, 0, 0);
    tbl[23] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[24] = v(1, 0, 0, 1, 1, 2, T, 1, 0, 0);
    tbl[25] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), '0);
    reset = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tx_valid = tbl[i].tv;
      rx_ready = tbl[i].rr;
      t_dout = tbl[i].dout;
      #1;
      chk($sformatf("row%0d", i), outs(), tbl[i].exp);
      @(negedge clk);
    end
    tx_valid = 1'b0; rx_ready = 1'b0; t_dout = '0;

    // FIFO fills with rx_ready low; RX polling stops while TX is still serviced
    model_on = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) in_q.push_back(64'hA0 + 64'(i));
    for (int c = 0; c < 100 && in_q.size() > 1; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("full_state", {rx_valid, 32'(in_q.size())}, {1'b1, 32'd1});
    r01 = 0; r00 = 0;
    tx_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    end
    chk("full_no_poll", {32'(r01), 32'(r00)}, '0);
    chk("full_tx_served", {32'(wr_cnt), last_wr}, {32'd1, T});
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 30 && !rx_valid; c++) @(negedge clk);
      chk($sformatf("pop%0d", i), {rx_valid, rx_data}, {1'b1, 64'hA0 + 64'(i)});
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      @(negedge clk);
    end
    chk("resume_poll", 1'(r01 > 0), 1'b1);

    // Output buffer busy: only status polls until it frees up
    do_reset();
    out_busy = 1'b1;
    tx_valid = 1'b1;
    repeat (40) @(negedge clk);
    chk("busy_no_write", {32'(wr_cnt), 32'(txr_cnt), 1'(r11 >= 2)}, {64'd0, 1'b1});
    out_busy = 1'b0;
    begin
      int c;
      for (c = 0; c < 20 && !tx_ready; c++) @(negedge clk);
      chk("busy_release_ready", tx_ready, 1'b1);
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_release_write", {32'(wr_cnt), 32'(txr_cnt), last_wr}, {32'd1, 32'd1, T});

    // Continuous demand on both sides alternates, then reset lands in TX_CHK
    do_reset();
    out_busy = 1'b1;
    tx_valid = 1'b1;
    repeat (40) @(negedge clk);
    begin
      logic ok;
      ok = turn_log.size() >= 6 && turn_log[0] == "R";
      for (int i = 1; i < turn_log.size(); i++) if (turn_log[i] == turn_log[i-1]) ok = 1'b0;
      chk("alternate", ok, 1'b1);
    end
    begin
      int c;
      for (c = 0; c < 20 && !(nic_en && !nic_wr_en && nic_addr == 2'b11); c++) @(negedge clk);
      chk("find_tx_stat", 1'(c < 20), 1'b1);
    end
    out_busy = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset_in_tx_chk", outs(), '0);
    begin
      int w0;
      w0 = wr_cnt;
      repeat (2) @(negedge clk);
      chk("no_write_after_reset", {32'(wr_cnt), 32'(txr_cnt)}, {32'(w0), 32'd0});
    end
    turn_log.delete();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("first_turn_rx", {1'(turn_log.size() >= 1), (turn_log.size() >= 1) ? turn_log[0] : 8'd0},
        {1'b1, 8'(byte'("R"))});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
